bcd_vga_overlay: RTL and testbench

- Downstream consumer of the 12-bit BCD converter: takes a packed 3-digit BCD value (hundreds, tens, ones) and draws it as scaled 8x8 glyphs into the VGA pixel stream.
- Sits between the pixel-coordinate generator and the DAC output register.
- Latches the BCD value once per frame so digits never tear mid-frame.
- Fixed 2-cycle pipeline; background pixels pass through unchanged.

---
 rtl/bcd_vga_overlay_pkg.sv | 39 +++
 rtl/bcd_vga_overlay_if.sv | 18 +
 rtl/bcd_vga_overlay_digit_font_rom.sv | 18 +
 rtl/bcd_vga_overlay.sv | 109 ++++++++++
 tb/tb_bcd_vga_overlay.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/bcd_vga_overlay_pkg.sv
// Shared definitions for the BCD-on-VGA overlay: font, digit indices, widths.
package bcd_vga_pkg;

   localparam int RGB_W      = 24;
   localparam int GLYPH_BASE = 8;

   // Which of the three digit cells a pixel falls into.
   typedef enum logic [1:0] {
      DIG_HUNDREDS = 2'd0,
      DIG_TENS     = 2'd1,
      DIG_ONES     = 2'd2,
      DIG_NONE     = 2'd3
   } digit_idx_t;

   // 10 glyphs x 8 rows x 8 bits; row 0 in the top byte, bit 7 leftmost.
   localparam logic [63:0] FONT [0:9] = '{
      64'h3C666E7666663C00,  // 0
      64'h1838181818187E00,  // 1
      64'h3C66060C30607E00,  // 2
      64'h3C66061C06663C00,  // 3
      64'h0C1C2C4C7E0C0C00,  // 4
      64'h7E607C0606663C00,  // 5
      64'h3C66607C66663C00,  // 6
      64'h7E660C1818181800,  // 7
      64'h3C66663C66663C00,  // 8
      64'h3C66663E06663C00   // 9
   };

   // Whole glyph for a nibble; anything above 9 is blank.
   function automatic logic [63:0] font_glyph(input logic [3:0] digit);
      logic [63:0] g;
      g = 64'h0;
      for (int i = 0; i < 10; i++) begin
         if (digit == 4'(i)) g = FONT[i];
      end
      return g;
   endfunction

endpackage

// File: rtl/bcd_vga_overlay_if.sv
// Pixel stream in/out of the overlay. The pixel stream has no back-pressure:
// a pixel is transferred on every clock where pix_valid=1 (there is no ready),
// and out_valid marks the matching composited pixel exactly two clocks later.
interface bcd_vga_overlay_if;
   logic        pix_valid;
   logic [9:0]  pix_x;
   logic [9:0]  pix_y;
   logic [23:0] rgb_in;
   logic        out_valid;
   logic [23:0] out_rgb;

   // Coordinate generator / DAC side.
   modport master (output pix_valid, pix_x, pix_y, rgb_in,
                   input  out_valid, out_rgb);
   // Overlay side.
   modport slave  (input  pix_valid, pix_x, pix_y, rgb_in,
                   output out_valid, out_rgb);
endinterface

// File: rtl/bcd_vga_overlay_digit_font_rom.sv
// Combinational 8x8 font row lookup; digits above 9 return an empty row.
module digit_font_rom
   import bcd_vga_pkg::*;
(
   input  logic [3:0] digit,
   input  logic [2:0] row,
   output logic [7:0] bits
);

   logic [63:0] glyph;

   // Pick the glyph, then the row; ~row maps row 0 onto the top byte.
   always_comb begin
      glyph = font_glyph(digit);
      bits  = glyph[{~row, 3'b000} +: 8];
   end

endmodule

// File: rtl/bcd_vga_overlay.sv
// Draws a latched 3-digit BCD value as scaled 8x8 glyphs over a pixel stream.
// Fixed 2-cycle pipeline, no stalls. Optional leading-zero blanking is
// enabled by defining BCD_LZB_EN.
module bcd_vga_overlay
   import bcd_vga_pkg::*;
#(
   parameter int               X0         = 16,
   parameter int               Y0         = 16,
   parameter int               SCALE_LOG2 = 1,
   parameter logic [RGB_W-1:0] FG_RGB     = 24'hFFFFFF
)(
   input  logic              clk,
   input  logic              reset_n,
   input  logic [11:0]       bcd_in,
   input  logic              frame_start,
   bcd_vga_overlay_if.slave  bus
);

   localparam int          G     = GLYPH_BASE << SCALE_LOG2;
   localparam logic [10:0] G_1   = 11'(G);
   localparam logic [10:0] G_2   = 11'(2 * G);
   localparam logic [10:0] G_3   = 11'(3 * G);

   logic [11:0]      bcd_latched;

   // Stage-1 combinational decode
   logic [10:0]      dx, dy;
   logic             in_box;
   digit_idx_t       digit;
   logic [3:0]       nibble;
   logic             blank;

   // Stage-1 registers
   logic             s1_valid;
   logic             s1_lit_en;
   logic [3:0]       s1_nibble;
   logic [2:0]       s1_row;
   logic [2:0]       s1_col;
   logic [RGB_W-1:0] s1_rgb;

   logic [7:0]       font_bits;

   // Hold the displayed value for a whole frame so digits never tear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)         bcd_latched <= 12'h000;
      else if (frame_start) bcd_latched <= bcd_in;
   end

   // Box test with 11-bit offsets: a negative offset (bit 10) is outside.
   always_comb begin
      dx     = {1'b0, bus.pix_x} - 11'(X0);
      dy     = {1'b0, bus.pix_y} - 11'(Y0);
      in_box = !dx[10] && !dy[10] && (dx < G_3) && (dy < G_1);
      if (dx < G_1)      digit = DIG_HUNDREDS;
      else if (dx < G_2) digit = DIG_TENS;
      else               digit = DIG_ONES;
      case (digit)
         DIG_HUNDREDS: nibble = bcd_latched[11:8];
         DIG_TENS:     nibble = bcd_latched[7:4];
         default:      nibble = bcd_latched[3:0];
      endcase
`ifdef BCD_LZB_EN
      case (digit)
         DIG_HUNDREDS: blank = (bcd_latched[11:8] == 4'd0);
         DIG_TENS:     blank = (bcd_latched[11:4] == 8'd0);
         default:      blank = 1'b0;
      endcase
`else
      blank = 1'b0;
`endif
   end

   // Stage 1: register the decoded cell position alongside the background.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid  <= 1'b0;
         s1_lit_en <= 1'b0;
         s1_nibble <= 4'h0;
         s1_row    <= 3'd0;
         s1_col    <= 3'd0;
         s1_rgb    <= '0;
      end else begin
         s1_valid  <= bus.pix_valid;
         s1_lit_en <= in_box && !blank;
         s1_nibble <= nibble;
         s1_row    <= dy[SCALE_LOG2 + 2 -: 3];
         s1_col    <= dx[SCALE_LOG2 + 2 -: 3];
         s1_rgb    <= bus.rgb_in;
      end
   end

   digit_font_rom u_rom (
      .digit (s1_nibble),
      .row   (s1_row),
      .bits  (font_bits)
   );

   // Stage 2: composite; column 0 is bit 7 of the font row.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.out_valid <= 1'b0;
         bus.out_rgb   <= '0;
      end else begin
         bus.out_valid <= s1_valid;
         bus.out_rgb   <= (s1_lit_en && font_bits[~s1_col]) ? FG_RGB : s1_rgb;
      end
   end

endmodule

// File: tb/tb_bcd_vga_overlay.sv
// Directed bench for bcd_vga_overlay (default parameters: box x 16..63, y 16..31,
// 16-pixel cells, each font pixel 2x2). Inputs change on the falling edge,
// outputs are sampled on the falling edge.
module tb_bcd_vga_overlay;

   localparam logic [23:0] FG = 24'hFFFFFF;
`ifdef BCD_LZB_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   logic        clk;
   logic        reset_n;
   logic [11:0] bcd_in;
   logic        frame_start;
   int          compared;
   int          mismatched;

   bcd_vga_overlay_if bus();

   bcd_vga_overlay dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .bcd_in      (bcd_in),
      .frame_start (frame_start),
      .bus         (bus)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One pixel in, a bubble behind it, result checked two clocks later.
   task automatic pixel(input string tag, input logic [9:0] x, input logic [9:0] y,
                        input logic [23:0] bg, input logic [23:0] exp);
      @(negedge clk);
      check({tag, " bubble"}, {23'h0, bus.out_valid}, 24'h0);
      bus.pix_valid = 1'b1;
      bus.pix_x     = x;
      bus.pix_y     = y;
      bus.rgb_in    = bg;
      @(negedge clk);
      bus.pix_valid = 1'b0;
      bus.pix_x     = 10'(($urandom_range(0, 1023)));
      bus.rgb_in    = 24'h0;
      @(negedge clk);
      check({tag, " valid"}, {23'h0, bus.out_valid}, 24'h1);
      check({tag, " rgb"}, bus.out_rgb, exp);
   endtask

   task automatic latch(input logic [11:0] v);
      @(negedge clk);
      bcd_in      = v;
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   initial begin
      compared      = 0;
      mismatched    = 0;
      reset_n       = 1'b0;
      bcd_in        = 12'h000;
      frame_start   = 1'b0;
      bus.pix_valid = 1'b0;
      bus.pix_x     = 10'd0;
      bus.pix_y     = 10'd0;
      bus.rgb_in    = 24'h0;

      // Reset state
      repeat (2) @(negedge clk);
      check("reset out_valid", {23'h0, bus.out_valid}, 24'h0);
      check("reset out_rgb", bus.out_rgb, 24'h0);
      reset_n = 1'b1;

      // Outside the box: passthrough
      pixel("origin", 10'd0, 10'd0, 24'h102030, 24'h102030);

      // Value 105: hundreds '1', tens '0', ones '5'
      latch(12'h105);
      pixel("h1 col1", 10'd18, 10'd16, 24'h000080, 24'h000080);
      pixel("h1 col3", 10'd22, 10'd16, 24'h000080, FG);
      pixel("h1 row6", 10'd18, 10'd28, 24'h000081, FG);
      pixel("t0 col0", 10'd32, 10'd16, 24'h000082, 24'h000082);
      pixel("t0 col2", 10'd36, 10'd16, 24'h000082, FG);
      pixel("o5 row3", 10'd61, 10'd22, 24'h000083, FG);

      // Box edges
      pixel("edge 63", 10'd63, 10'd16, 24'h000084, 24'h000084);
      pixel("edge 64", 10'd64, 10'd16, 24'h000085, 24'h000085);
      pixel("edge y32", 10'd22, 10'd32, 24'h000086, 24'h000086);
      pixel("edge x15", 10'd15, 10'd16, 24'h000087, 24'h000087);
      pixel("edge y15", 10'd22, 10'd15, 24'h000088, 24'h000088);

      // Invalid hundreds nibble renders blank; tens still drawn
      latch(12'hA00);
      pixel("hA blank", 10'd22, 10'd16, 24'h000090, 24'h000090);
      pixel("hA t0", 10'd36, 10'd16, 24'h000091, FG);

      // bcd_in changes without frame_start: display holds
      @(negedge clk);
      bcd_in = 12'h111;
      pixel("hold t0", 10'd36, 10'd16, 24'h000092, FG);

      // Leading zeros (blank only with BCD_LZB_EN)
      latch(12'h007);
      pixel("lz h0", 10'd22, 10'd16, 24'h0000A0, LZB ? 24'h0000A0 : FG);
      pixel("lz t0", 10'd36, 10'd16, 24'h0000A1, LZB ? 24'h0000A1 : FG);
      pixel("lz o7", 10'd52, 10'd16, 24'h0000A2, FG);

      // Reset mid-frame: output clears without waiting for a clock
      @(negedge clk);
      bus.pix_valid = 1'b1;
      bus.pix_x     = 10'd52;
      bus.pix_y     = 10'd16;
      bus.rgb_in    = 24'h0000B0;
      @(negedge clk);
      bus.pix_valid = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      check("midrst out_valid", {23'h0, bus.out_valid}, 24'h0);
      check("midrst out_rgb", bus.out_rgb, 24'h0);
      @(negedge clk);
      reset_n = 1'b1;

      // After reset the latched value is 000
      pixel("rst h0", 10'd22, 10'd16, 24'h0000C0, LZB ? 24'h0000C0 : FG);
      pixel("rst t0", 10'd36, 10'd16, 24'h0000C1, LZB ? 24'h0000C1 : FG);
      pixel("rst o0", 10'd52, 10'd16, 24'h0000C2, FG);

      // Pixel in the frame_start cycle uses the old value (ones '0')
      @(negedge clk);
      bcd_in        = 12'h111;
      frame_start   = 1'b1;
      bus.pix_valid = 1'b1;
      bus.pix_x     = 10'd52;
      bus.pix_y     = 10'd16;
      bus.rgb_in    = 24'h0000D0;
      @(negedge clk);
      frame_start   = 1'b0;
      bus.pix_valid = 1'b0;
      @(negedge clk);
      check("fs same valid", {23'h0, bus.out_valid}, 24'h1);
      check("fs same rgb", bus.out_rgb, FG);
      // Next pixel sees ones '1': column 2 of 0x18 is dark
      pixel("fs next", 10'd52, 10'd16, 24'h0000D1, 24'h0000D1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
